// File: rtl/rename_regfile_if.sv
// Rename/regfile port bundle: source lookups, destination rename, commits and checkpoint control.
// The master is the pipeline front end; the slave is the rename register file.
interface rename_regfile_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREG  = 32,
    parameter int unsigned ROB_W = 4,
    parameter int unsigned NRP   = 2,
    parameter int unsigned NCP   = 2,
    parameter int unsigned NCKPT = 4
);
    localparam int unsigned RW = $clog2(NREG);
    localparam int unsigned CW = $clog2(NCKPT);

    logic                  rdy_in;
    logic [NRP*RW-1:0]     rd_addr_in;
    logic [NRP-1:0]        rd_busy_out;
    logic [NRP*XLEN-1:0]   rd_value_out;
    logic [NRP*ROB_W-1:0]  rd_tag_out;
    logic                  disp_en_in;
    logic [RW-1:0]         disp_rd_in;
    logic [ROB_W-1:0]      disp_tag_in;
    logic [NCP-1:0]        cm_en_in;
    logic [NCP*RW-1:0]     cm_rd_in;
    logic [NCP*XLEN-1:0]   cm_value_in;
    logic [NCP*ROB_W-1:0]  cm_tag_in;
    logic                  ckpt_save_in;
    logic                  ckpt_restore_in;
    logic [CW-1:0]         ckpt_id_in;
    logic                  flush_in;
    logic                  ckpt_err_out;

    modport master (
        output rdy_in, rd_addr_in, disp_en_in, disp_rd_in, disp_tag_in,
               cm_en_in, cm_rd_in, cm_value_in, cm_tag_in,
               ckpt_save_in, ckpt_restore_in, ckpt_id_in, flush_in,
        input  rd_busy_out, rd_value_out, rd_tag_out, ckpt_err_out
    );

    modport slave (
        input  rdy_in, rd_addr_in, disp_en_in, disp_rd_in, disp_tag_in,
               cm_en_in, cm_rd_in, cm_value_in, cm_tag_in,
               ckpt_save_in, ckpt_restore_in, ckpt_id_in, flush_in,
        output rd_busy_out, rd_value_out, rd_tag_out, ckpt_err_out
    );
endinterface

// File: rtl/rename_regfile.sv
// Architectural register file with rename map (busy/ROB tag per register) and map checkpoints.
// Reads are combinational with commit bypass; all state updates on the rising clock edge.
module rename_regfile #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREG  = 32,
    parameter int unsigned ROB_W = 4,
    parameter int unsigned NRP   = 2,
    parameter int unsigned NCP   = 2,
    parameter int unsigned NCKPT = 4
) (
    input logic            clk_in,
    input logic            rst_n_in,
    rename_regfile_if.slave rf
);
    localparam int unsigned RW  = $clog2(NREG);
    localparam int unsigned CW  = $clog2(NCKPT);
    localparam int unsigned CPW = (NCP > 1) ? $clog2(NCP) : 1;

    logic [XLEN-1:0]  val_q     [NREG];
    logic [XLEN-1:0]  val_d     [NREG];
    logic [NREG-1:0]  busy_q, busy_d;
    logic [ROB_W-1:0] tag_q     [NREG];
    logic [ROB_W-1:0] tag_d     [NREG];
    logic [NREG-1:0]  ck_busy_q [NCKPT];
    logic [NREG-1:0]  ck_busy_d [NCKPT];
    logic [ROB_W-1:0] ck_tag_q  [NCKPT][NREG];
    logic [ROB_W-1:0] ck_tag_d  [NCKPT][NREG];
    logic [NCKPT-1:0] ck_valid_q, ck_valid_d;
    logic             err_q, err_d;

    logic [NCP-1:0]   cm_en_c;
    logic [RW-1:0]    cm_rd_c  [NCP];
    logic [XLEN-1:0]  cm_val_c [NCP];
    logic [ROB_W-1:0] cm_tag_c [NCP];

    // A frozen cycle must not leak commit bypass into reads either.
    assign cm_en_c = rf.cm_en_in & {NCP{rf.rdy_in}};

    always_comb begin
        for (int unsigned c = 0; c < NCP; c++) begin
            cm_rd_c[CPW'(c)]  = rf.cm_rd_in[c*RW +: RW];
            cm_val_c[CPW'(c)] = rf.cm_value_in[c*XLEN +: XLEN];
            cm_tag_c[CPW'(c)] = rf.cm_tag_in[c*ROB_W +: ROB_W];
        end
    end

    // Source lookup: pre-dispatch map, commit value/clear bypass, x0 hardwired to zero.
    always_comb begin
        logic [RW-1:0]    ra;
        logic             rb;
        logic [ROB_W-1:0] rt;
        logic [XLEN-1:0]  rv;
        ra = '0;
        rb = 1'b0;
        rt = '0;
        rv = '0;
        rf.rd_busy_out  = '0;
        rf.rd_value_out = '0;
        rf.rd_tag_out   = '0;
        for (int unsigned p = 0; p < NRP; p++) begin
            ra = rf.rd_addr_in[p*RW +: RW];
            rb = busy_q[ra];
            rt = tag_q[ra];
            rv = val_q[ra];
            for (int unsigned c = 0; c < NCP; c++) begin
                if (cm_en_c[CPW'(c)] && cm_rd_c[CPW'(c)] == ra) begin
                    rv = cm_val_c[CPW'(c)];
                    if (busy_q[ra] && tag_q[ra] == cm_tag_c[CPW'(c)]) begin
                        rb = 1'b0;
                        rt = '0;
                    end
                end
            end
            if (ra == '0) begin
                rb = 1'b0;
                rt = '0;
                rv = '0;
            end
            rf.rd_busy_out[p +: 1]          = rb;
            rf.rd_tag_out[p*ROB_W +: ROB_W] = rt;
            rf.rd_value_out[p*XLEN +: XLEN] = rv;
        end
    end

    // Next state: commits first, then flush > restore > (dispatch, save).
    always_comb begin
        logic [RW-1:0] a;
        a          = '0;
        val_d      = val_q;
        busy_d     = busy_q;
        tag_d      = tag_q;
        ck_busy_d  = ck_busy_q;
        ck_tag_d   = ck_tag_q;
        ck_valid_d = ck_valid_q;
        err_d      = err_q;
        if (rf.rdy_in) begin
            err_d = 1'b0;
            for (int unsigned c = 0; c < NCP; c++) begin
                a = cm_rd_c[CPW'(c)];
                if (cm_en_c[CPW'(c)]) begin
                    if (a != '0) begin
                        val_d[a] = cm_val_c[CPW'(c)];
                    end
                    if (busy_q[a] && tag_q[a] == cm_tag_c[CPW'(c)]) begin
                        busy_d[a] = 1'b0;
                        tag_d[a]  = '0;
                    end
                    for (int unsigned k = 0; k < NCKPT; k++) begin
                        if (ck_valid_q[CW'(k)] && ck_busy_q[CW'(k)][a] &&
                            ck_tag_q[CW'(k)][a] == cm_tag_c[CPW'(c)]) begin
                            ck_busy_d[CW'(k)][a] = 1'b0;
                            ck_tag_d[CW'(k)][a]  = '0;
                        end
                    end
                end
            end
            if (rf.flush_in) begin
                busy_d     = '0;
                ck_valid_d = '0;
                for (int unsigned r = 0; r < NREG; r++) begin
                    tag_d[RW'(r)] = '0;
                end
            end else if (rf.ckpt_restore_in) begin
                if (ck_valid_q[rf.ckpt_id_in]) begin
                    busy_d = ck_busy_d[rf.ckpt_id_in];
                    for (int unsigned r = 0; r < NREG; r++) begin
                        tag_d[RW'(r)] = ck_tag_d[rf.ckpt_id_in][RW'(r)];
                    end
                    ck_valid_d[rf.ckpt_id_in] = 1'b0;
                end else begin
                    err_d = 1'b1;
                end
            end else begin
                if (rf.disp_en_in && rf.disp_rd_in != '0) begin
                    busy_d[rf.disp_rd_in] = 1'b1;
                    tag_d[rf.disp_rd_in]  = rf.disp_tag_in;
                end
                if (rf.ckpt_save_in) begin
                    ck_busy_d[rf.ckpt_id_in] = busy_d;
                    for (int unsigned r = 0; r < NREG; r++) begin
                        ck_tag_d[rf.ckpt_id_in][RW'(r)] = tag_d[RW'(r)];
                    end
                    ck_valid_d[rf.ckpt_id_in] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int unsigned r = 0; r < NREG; r++) begin
                val_q[RW'(r)] <= '0;
                tag_q[RW'(r)] <= '0;
            end
            for (int unsigned k = 0; k < NCKPT; k++) begin
                ck_busy_q[CW'(k)] <= '0;
                for (int unsigned r = 0; r < NREG; r++) begin
                    ck_tag_q[CW'(k)][RW'(r)] <= '0;
                end
            end
            busy_q     <= '0;
            ck_valid_q <= '0;
            err_q      <= 1'b0;
        end else begin
            val_q      <= val_d;
            busy_q     <= busy_d;
            tag_q      <= tag_d;
            ck_busy_q  <= ck_busy_d;
            ck_tag_q   <= ck_tag_d;
            ck_valid_q <= ck_valid_d;
            err_q      <= err_d;
        end
    end

    assign rf.ckpt_err_out = err_q;
endmodule

// File: tb/tb_rename_regfile.sv
// Self-checking bench for rename_regfile: directed scenarios plus random traffic against a
// register-level model of the rename rules.
module tb_rename_regfile;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREG  = 32;
    localparam int unsigned ROB_W = 4;
    localparam int unsigned NRP   = 2;
    localparam int unsigned NCP   = 2;
    localparam int unsigned NCKPT = 4;
    localparam int unsigned RW    = 5;

    logic clk_in = 1'b0;
    logic rst_n_in;
    int   checks = 0;
    int   errors = 0;

    always #5 clk_in = ~clk_in;

    rename_regfile_if #(.XLEN(XLEN), .NREG(NREG), .ROB_W(ROB_W), .NRP(NRP), .NCP(NCP),
                        .NCKPT(NCKPT)) rf ();

    rename_regfile #(.XLEN(XLEN), .NREG(NREG), .ROB_W(ROB_W), .NRP(NRP), .NCP(NCP),
                     .NCKPT(NCKPT)) dut (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .rf       (rf)
    );

    // Reference state: architectural values, rename map and checkpoint slots.
    logic [31:0] m_val  [NREG];
    bit          m_busy [NREG];
    logic [3:0]  m_tag  [NREG];
    bit          ck_v   [NCKPT];
    bit          ck_b   [NCKPT][NREG];
    logic [3:0]  ck_t   [NCKPT][NREG];
    bit          m_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < NREG; r++) begin
            m_val[r] = '0; m_busy[r] = 1'b0; m_tag[r] = '0;
        end
        for (int k = 0; k < NCKPT; k++) begin
            ck_v[k] = 1'b0;
            for (int r = 0; r < NREG; r++) begin
                ck_b[k][r] = 1'b0; ck_t[k][r] = '0;
            end
        end
        m_err = 1'b0;
    endtask

    function automatic int cm_rd(input int c);
        return int'(rf.cm_rd_in[c*RW +: RW]);
    endfunction

    // True when any live commit retires the rename (busy, tag) held for register r.
    function automatic bit retires(input bit b, input logic [3:0] t, input int r);
        bit h = 1'b0;
        for (int c = 0; c < NCP; c++)
            if (rf.rdy_in && rf.cm_en_in[c] && cm_rd(c) == r && b &&
                t == rf.cm_tag_in[c*ROB_W +: ROB_W]) h = 1'b1;
        return h;
    endfunction

    task automatic exp_read(input int a, output bit b, output logic [3:0] t, output logic [31:0] v);
        b = m_busy[a]; t = m_tag[a]; v = m_val[a];
        for (int c = 0; c < NCP; c++)
            if (rf.rdy_in && rf.cm_en_in[c] && cm_rd(c) == a) v = rf.cm_value_in[c*XLEN +: XLEN];
        if (retires(m_busy[a], m_tag[a], a)) b = 1'b0;
        if (a == 0) begin b = 1'b0; t = '0; v = '0; end
    endtask

    task automatic model_update();
        int id;
        if (!rf.rdy_in) return;
        id = int'(rf.ckpt_id_in);
        for (int k = 0; k < NCKPT; k++)
            if (ck_v[k])
                for (int r = 0; r < NREG; r++)
                    if (retires(ck_b[k][r], ck_t[k][r], r)) begin ck_b[k][r] = 1'b0; ck_t[k][r] = '0; end
        for (int r = 0; r < NREG; r++)
            if (retires(m_busy[r], m_tag[r], r)) begin m_busy[r] = 1'b0; m_tag[r] = '0; end
        for (int c = 0; c < NCP; c++)
            if (rf.cm_en_in[c] && cm_rd(c) != 0) m_val[cm_rd(c)] = rf.cm_value_in[c*XLEN +: XLEN];
        m_err = 1'b0;
        if (rf.flush_in) begin
            for (int r = 0; r < NREG; r++) begin m_busy[r] = 1'b0; m_tag[r] = '0; end
            for (int k = 0; k < NCKPT; k++) ck_v[k] = 1'b0;
        end else if (rf.ckpt_restore_in) begin
            if (ck_v[id]) begin
                for (int r = 0; r < NREG; r++) begin m_busy[r] = ck_b[id][r]; m_tag[r] = ck_t[id][r]; end
                ck_v[id] = 1'b0;
            end else m_err = 1'b1;
        end else begin
            if (rf.disp_en_in && rf.disp_rd_in != 0) begin
                m_busy[int'(rf.disp_rd_in)] = 1'b1;
                m_tag[int'(rf.disp_rd_in)]  = rf.disp_tag_in;
            end
            if (rf.ckpt_save_in) begin
                for (int r = 0; r < NREG; r++) begin ck_b[id][r] = m_busy[r]; ck_t[id][r] = m_tag[r]; end
                ck_v[id] = 1'b1;
            end
        end
    endtask

    task automatic idle();
        rf.rdy_in = 1'b1; rf.rd_addr_in = '0;
        rf.disp_en_in = 1'b0; rf.disp_rd_in = '0; rf.disp_tag_in = '0;
        rf.cm_en_in = '0; rf.cm_rd_in = '0; rf.cm_value_in = '0; rf.cm_tag_in = '0;
        rf.ckpt_save_in = 1'b0; rf.ckpt_restore_in = 1'b0; rf.ckpt_id_in = '0; rf.flush_in = 1'b0;
    endtask

    task automatic set_rd(input int p, input int a);
        rf.rd_addr_in[p*RW +: RW] = RW'(a);
    endtask

    task automatic set_disp(input int r, input int t);
        rf.disp_en_in = 1'b1; rf.disp_rd_in = RW'(r); rf.disp_tag_in = ROB_W'(t);
    endtask

    task automatic set_cm(input int p, input int r, input logic [31:0] v, input int t);
        rf.cm_en_in[p] = 1'b1;
        rf.cm_rd_in[p*RW +: RW] = RW'(r);
        rf.cm_value_in[p*XLEN +: XLEN] = v;
        rf.cm_tag_in[p*ROB_W +: ROB_W] = ROB_W'(t);
    endtask

    task automatic set_ckpt(input bit save, input bit restore, input int id);
        rf.ckpt_save_in = save; rf.ckpt_restore_in = restore; rf.ckpt_id_in = 2'(id);
    endtask

    // Compare both read ports and the error pulse against the model, mid-cycle.
    task automatic settle();
        #1;
        for (int p = 0; p < NRP; p++) begin
            int a;
            bit eb;
            logic [3:0] et;
            logic [31:0] ev;
            a = int'(rf.rd_addr_in[p*RW +: RW]);
            exp_read(a, eb, et, ev);
            check($sformatf("rd%0d_busy x%0d", p, a), 32'(rf.rd_busy_out[p]), 32'(eb));
            check($sformatf("rd%0d_value x%0d", p, a), rf.rd_value_out[p*XLEN +: XLEN], ev);
            if (eb) check($sformatf("rd%0d_tag x%0d", p, a), 32'(rf.rd_tag_out[p*ROB_W +: ROB_W]), 32'(et));
        end
        check("ckpt_err", 32'(rf.ckpt_err_out), 32'(m_err));
    endtask

    task automatic advance();
        model_update();
        @(negedge clk_in);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n_in = 1'b1;
        idle();
        model_reset();
        #1 rst_n_in = 1'b0;
        set_rd(0, 5);
        #2;
        check("reset busy x5", 32'(rf.rd_busy_out[0]), 32'd0);
        check("reset value x5", rf.rd_value_out[31:0], 32'd0);
        check("reset err", 32'(rf.ckpt_err_out), 32'd0);
        @(negedge clk_in);
        rst_n_in = 1'b1;

        // Bypass on same-cycle commit clear.
        idle(); set_rd(0, 5); set_disp(5, 3); settle(); advance();
        idle(); set_rd(0, 5); set_cm(0, 5, 32'hAA, 3); settle();
        check("s1 bypass busy", 32'(rf.rd_busy_out[0]), 32'd0);
        check("s1 bypass value", rf.rd_value_out[31:0], 32'hAA);
        advance();
        idle(); set_rd(0, 5); settle();
        check("s1 after busy", 32'(rf.rd_busy_out[0]), 32'd0);
        advance();

        // Stale commit writes the value but leaves the younger rename in place.
        idle(); set_disp(5, 3); settle(); advance();
        idle(); set_rd(0, 5); set_disp(5, 7); settle(); advance();
        idle(); set_rd(0, 5); set_cm(0, 5, 32'h11, 3); settle(); advance();
        idle(); set_rd(0, 5); settle();
        check("s2 value", rf.rd_value_out[31:0], 32'h11);
        check("s2 busy", 32'(rf.rd_busy_out[0]), 32'd1);
        check("s2 tag", 32'(rf.rd_tag_out[3:0]), 32'd7);
        advance();

        // Dual commit to one register: port 1 value, clear on either tag.
        idle(); set_disp(9, 4); settle(); advance();
        idle(); set_rd(1, 9); set_cm(0, 9, 32'd1, 2); set_cm(1, 9, 32'd2, 4); settle(); advance();
        idle(); set_rd(1, 9); settle();
        check("s3 value", rf.rd_value_out[63:32], 32'd2);
        check("s3 busy", 32'(rf.rd_busy_out[1]), 32'd0);
        advance();

        // Checkpoint save, commit into the slot, restore, then reuse of the consumed slot.
        idle(); set_rd(0, 5); set_ckpt(1'b1, 1'b0, 1); settle(); advance();
        idle(); set_disp(6, 8); settle(); advance();
        idle(); set_rd(0, 5); set_rd(1, 6); set_cm(0, 5, 32'h22, 7); settle(); advance();
        idle(); set_rd(0, 5); set_rd(1, 6); set_ckpt(1'b0, 1'b1, 1); settle(); advance();
        idle(); set_rd(0, 5); set_rd(1, 6); settle();
        check("s4 x5 busy", 32'(rf.rd_busy_out[0]), 32'd0);
        check("s4 x6 busy", 32'(rf.rd_busy_out[1]), 32'd0);
        check("s4 x5 value", rf.rd_value_out[31:0], 32'h22);
        advance();
        idle(); set_ckpt(1'b0, 1'b1, 1); settle(); advance();
        idle(); settle();
        check("s4 slot1 invalid", 32'(rf.ckpt_err_out), 32'd1);
        advance();

        // Restore from a never-saved slot.
        idle(); set_disp(7, 5); settle(); advance();
        idle(); set_rd(0, 7); set_ckpt(1'b0, 1'b1, 2); settle(); advance();
        idle(); set_rd(0, 7); settle();
        check("s5 err pulse", 32'(rf.ckpt_err_out), 32'd1);
        check("s5 x7 busy", 32'(rf.rd_busy_out[0]), 32'd1);
        check("s5 x7 tag", 32'(rf.rd_tag_out[3:0]), 32'd5);
        advance();
        idle(); settle();
        check("s5 err gone", 32'(rf.ckpt_err_out), 32'd0);
        advance();

        // Random traffic on a small register/tag window to provoke collisions.
        for (int n = 0; n < 400; n++) begin
            idle();
            rf.rdy_in = ($urandom_range(0, 9) != 0);
            set_rd(0, int'($urandom_range(0, 7)));
            set_rd(1, int'($urandom_range(0, 7)));
            if ($urandom_range(0, 9) < 6) set_disp(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
            for (int c = 0; c < NCP; c++)
                if ($urandom_range(0, 1) == 1)
                    set_cm(c, int'($urandom_range(0, 7)), $urandom, int'($urandom_range(0, 3)));
            set_ckpt($urandom_range(0, 6) == 0, $urandom_range(0, 11) == 0, int'($urandom_range(0, 3)));
            rf.flush_in = ($urandom_range(0, 29) == 0);
            settle(); advance();
        end

        // Flush with competing dispatch/commit/save, then asynchronous reset mid-cycle.
        idle(); set_ckpt(1'b1, 1'b0, 0); settle(); advance();
        idle(); set_ckpt(1'b1, 1'b0, 3); set_disp(3, 2); settle(); advance();
        idle(); set_rd(0, 3); set_rd(1, 4); rf.flush_in = 1'b1; set_disp(3, 6);
        set_cm(0, 4, 32'h55, 1); set_ckpt(1'b1, 1'b0, 2); settle(); advance();
        idle(); set_rd(0, 3); set_rd(1, 4); settle();
        check("s6 x3 busy", 32'(rf.rd_busy_out[0]), 32'd0);
        check("s6 x4 busy", 32'(rf.rd_busy_out[1]), 32'd0);
        check("s6 x4 value", rf.rd_value_out[63:32], 32'h55);
        advance();
        idle(); set_ckpt(1'b0, 1'b1, 3); settle(); advance();
        idle(); set_ckpt(1'b0, 1'b1, 0); settle();
        check("s6 slot3 invalid", 32'(rf.ckpt_err_out), 32'd1);
        advance();
        idle(); set_rd(1, 4); settle();
        check("s6 slot0 invalid", 32'(rf.ckpt_err_out), 32'd1);
        #2 rst_n_in = 1'b0;
        #1;
        check("rst x4 value", rf.rd_value_out[63:32], 32'd0);
        check("rst x4 busy", 32'(rf.rd_busy_out[1]), 32'd0);
        check("rst err", 32'(rf.ckpt_err_out), 32'd0);
        model_reset();
        @(negedge clk_in);
        rst_n_in = 1'b1;
        idle(); set_rd(0, 5); set_rd(1, 7); settle();
        check("post rst x7 busy", 32'(rf.rd_busy_out[1]), 32'd0);
        set_disp(5, 1); advance();
        idle(); set_rd(0, 5); settle();
        check("post rst x5 busy", 32'(rf.rd_busy_out[0]), 32'd1);
        advance();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
